// File: rtl/axi4lite_timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_timer_slave
// Brief    : AXI4-lite timer peripheral with a prescaled up-counter, a compare
//            register and a registered level interrupt.
// Revision : 1.0
// ============================================================================

module axi4lite_timer_slave #(
    parameter int PRESCALE  = 4,
    parameter int ADDR_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,

    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,

    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,

    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,

    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,

    output logic        irq_out
);

    localparam logic [1:0]  c_IDLE        = 2'd0;
    localparam logic [1:0]  c_WRESP       = 2'd1;
    localparam logic [1:0]  c_RRESP       = 2'd2;

    localparam logic [1:0]  c_REG_CTRL    = 2'd0;
    localparam logic [1:0]  c_REG_COMPARE = 2'd1;
    localparam logic [1:0]  c_REG_COUNT   = 2'd2;
    localparam logic [1:0]  c_REG_STATUS  = 2'd3;

    localparam logic [15:0] c_PRESC_LAST  = 16'(PRESCALE - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    logic                 r_enable;
    logic                 r_irq_en;
    logic                 r_autoreload;
    logic                 r_pending;
    logic                 r_irq;
    logic [31:0]          r_compare;
    logic [31:0]          r_count;
    logic [31:0]          r_rdata;
    logic [15:0]          r_prescaler;

    logic [ADDR_BITS-1:0] w_waddr;
    logic [ADDR_BITS-1:0] w_raddr;
    logic [1:0]           w_wsel;
    logic [1:0]           w_rsel;
    logic                 w_wr_fire;
    logic                 w_rd_fire;
    logic                 w_any_strb;
    logic                 w_ctrl_wr;
    logic                 w_compare_wr;
    logic                 w_count_wr;
    logic                 w_status_wr;
    logic                 w_tick;
    logic [31:0]          w_count_inc;
    logic                 w_match;
    logic [31:0]          w_read_mux;
    logic                 w_unused;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Only addr[3:2] selects a register; the rest of the address and prot are don't-care.
    assign w_waddr  = mem_axi_awaddr[ADDR_BITS-1:0];
    assign w_raddr  = mem_axi_araddr[ADDR_BITS-1:0];
    assign w_wsel   = w_waddr[3:2];
    assign w_rsel   = w_raddr[3:2];
    assign w_unused = ^{w_waddr, w_raddr, mem_axi_awaddr, mem_axi_araddr,
                        mem_axi_awprot, mem_axi_arprot};

    // Write needs both address and data present; it takes priority over a read.
    assign w_wr_fire = !reset && (r_state == c_IDLE) && mem_axi_awvalid && mem_axi_wvalid;
    assign w_rd_fire = !reset && (r_state == c_IDLE) && mem_axi_arvalid
                       && !(mem_axi_awvalid && mem_axi_wvalid);

    // ------------------------------------------------------------------
    // Bus FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_wr_fire) begin
                    w_state_next = c_WRESP;
                end else if (w_rd_fire) begin
                    w_state_next = c_RRESP;
                end
            end
            c_WRESP: begin
                if (mem_axi_bready) begin
                    w_state_next = c_IDLE;
                end
            end
            c_RRESP: begin
                if (mem_axi_rready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        mem_axi_awready = w_wr_fire;
        mem_axi_wready  = w_wr_fire;
        mem_axi_arready = w_rd_fire;
        mem_axi_bvalid  = (r_state == c_WRESP);
        mem_axi_rvalid  = (r_state == c_RRESP);
    end

    // ------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------
    assign w_any_strb   = |mem_axi_wstrb;
    assign w_ctrl_wr    = w_wr_fire && (w_wsel == c_REG_CTRL)    && mem_axi_wstrb[0];
    assign w_compare_wr = w_wr_fire && (w_wsel == c_REG_COMPARE) && w_any_strb;
    assign w_count_wr   = w_wr_fire && (w_wsel == c_REG_COUNT)   && w_any_strb;
    assign w_status_wr  = w_wr_fire && (w_wsel == c_REG_STATUS)  && mem_axi_wstrb[0]
                          && mem_axi_wdata[0];

    // A bus write to COUNT suppresses both the increment and the match check.
    assign w_tick      = r_enable && (r_prescaler == c_PRESC_LAST);
    assign w_count_inc = r_count + 32'd1;
    assign w_match     = w_tick && !w_count_wr && (w_count_inc == r_compare);

    always_comb begin
        w_read_mux = 32'd0;
        case (w_rsel)
            c_REG_CTRL:    w_read_mux = {29'd0, r_autoreload, r_irq_en, r_enable};
            c_REG_COMPARE: w_read_mux = r_compare;
            c_REG_COUNT:   w_read_mux = r_count;
            c_REG_STATUS:  w_read_mux = {31'd0, r_pending};
            default:       w_read_mux = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Timer, registers and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler  <= 16'd0;
            r_count      <= 32'd0;
            r_compare    <= 32'd0;
            r_enable     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_autoreload <= 1'b0;
            r_pending    <= 1'b0;
            r_irq        <= 1'b0;
            r_rdata      <= 32'd0;
        end else begin
            if (!r_enable || w_tick) begin
                r_prescaler <= 16'd0;
            end else begin
                r_prescaler <= r_prescaler + 16'd1;
            end

            if (w_count_wr) begin
                r_count <= byte_merge(r_count, mem_axi_wdata, mem_axi_wstrb);
            end else if (w_match && r_autoreload) begin
                r_count <= 32'd0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
            end

            // One-shot mode stops itself on match unless software rewrites CTRL now.
            if (w_ctrl_wr) begin
                r_enable     <= mem_axi_wdata[0];
                r_irq_en     <= mem_axi_wdata[1];
                r_autoreload <= mem_axi_wdata[2];
            end else if (w_match && !r_autoreload) begin
                r_enable <= 1'b0;
            end

            if (w_compare_wr) begin
                r_compare <= byte_merge(r_compare, mem_axi_wdata, mem_axi_wstrb);
            end

            if (w_match) begin
                r_pending <= 1'b1;
            end else if (w_status_wr) begin
                r_pending <= 1'b0;
            end

            r_irq <= r_pending && r_irq_en;

            if (w_rd_fire) begin
                r_rdata <= w_read_mux;
            end
        end
    end

    assign mem_axi_rdata = r_rdata;
    assign irq_out       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_timer_slave
// Brief    : Directed self-checking bench for the AXI4-lite timer peripheral.
// Revision : 1.0
// ============================================================================

module tb_axi4lite_timer_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid;
    logic        mem_axi_bready;
    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;
    logic        irq_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int wr_hs;
    int hs;
    logic irq_hist [0:2047];

    axi4lite_timer_slave #(
        .PRESCALE  (4),
        .ADDR_BITS (4)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .mem_axi_awvalid (mem_axi_awvalid),
        .mem_axi_awready (mem_axi_awready),
        .mem_axi_awaddr  (mem_axi_awaddr),
        .mem_axi_awprot  (mem_axi_awprot),
        .mem_axi_wvalid  (mem_axi_wvalid),
        .mem_axi_wready  (mem_axi_wready),
        .mem_axi_wdata   (mem_axi_wdata),
        .mem_axi_wstrb   (mem_axi_wstrb),
        .mem_axi_bvalid  (mem_axi_bvalid),
        .mem_axi_bready  (mem_axi_bready),
        .mem_axi_arvalid (mem_axi_arvalid),
        .mem_axi_arready (mem_axi_arready),
        .mem_axi_araddr  (mem_axi_araddr),
        .mem_axi_arprot  (mem_axi_arprot),
        .mem_axi_rvalid  (mem_axi_rvalid),
        .mem_axi_rready  (mem_axi_rready),
        .mem_axi_rdata   (mem_axi_rdata),
        .irq_out         (irq_out)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N settles, cyc == N; irq_hist[N] is irq_out after edge N.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 2048) irq_hist[cyc] <= irq_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; address handshake lands on the next posedge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n;
        mem_axi_awvalid = 1'b1;
        mem_axi_wvalid  = 1'b1;
        mem_axi_awaddr  = addr;
        mem_axi_wdata   = data;
        mem_axi_wstrb   = strb;
        n = 0;
        @(negedge clk);
        while (!(mem_axi_awready && mem_axi_wready) && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready", {31'd0, mem_axi_awready && mem_axi_wready}, 32'd1);
        @(posedge clk);
        #1;
        wr_hs = cyc;
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_bready  = 1'b1;
        @(negedge clk);
        check("wr_bvalid", {31'd0, mem_axi_bvalid}, 32'd1);
        @(posedge clk);
        #1;
        mem_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp, input int hold);
        int n;
        mem_axi_arvalid = 1'b1;
        mem_axi_araddr  = addr;
        n = 0;
        @(negedge clk);
        while (!mem_axi_arready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("rd_arready", {31'd0, mem_axi_arready}, 32'd1);
        @(posedge clk);
        #1;
        mem_axi_arvalid = 1'b0;
        @(negedge clk);
        check("rd_rvalid", {31'd0, mem_axi_rvalid}, 32'd1);
        check(tag, mem_axi_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rd_hold_rvalid", {31'd0, mem_axi_rvalid}, 32'd1);
            check("rd_hold_rdata", mem_axi_rdata, exp);
        end
        mem_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        mem_axi_rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        mem_axi_awvalid = 1'b0;
        mem_axi_awaddr  = 32'd0;
        mem_axi_awprot  = 3'd0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_wdata   = 32'd0;
        mem_axi_wstrb   = 4'd0;
        mem_axi_bready  = 1'b0;
        mem_axi_arvalid = 1'b0;
        mem_axi_araddr  = 32'd0;
        mem_axi_arprot  = 3'd0;
        mem_axi_rready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshake", {27'd0, mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
                                mem_axi_arready, mem_axi_rvalid}, 32'd0);
        check("rst_rdata", mem_axi_rdata, 32'd0);
        check("rst_irq", {31'd0, irq_out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values of all four registers; first read holds rready low for 5 cycles.
        axi_read("rst_ctrl",    32'h0, 32'd0, 5);
        axi_read("rst_compare", 32'h4, 32'd0, 0);
        axi_read("rst_count",   32'h8, 32'd0, 0);
        axi_read("rst_status",  32'hC, 32'd0, 0);

        // awvalid leads wvalid by 3 cycles; strobed write of COMPARE.
        mem_axi_awvalid = 1'b1;
        mem_axi_awaddr  = 32'h4;
        mem_axi_wdata   = 32'h1234_5678;
        mem_axi_wstrb   = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_only_ready", {30'd0, mem_axi_awready, mem_axi_wready}, 32'd0);
            @(posedge clk);
            #1;
        end
        mem_axi_wvalid = 1'b1;
        @(negedge clk);
        check("aw_w_ready", {30'd0, mem_axi_awready, mem_axi_wready}, 32'd3);
        @(posedge clk);
        #1;
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_bready  = 1'b1;
        @(negedge clk);
        check("strb_bvalid", {31'd0, mem_axi_bvalid}, 32'd1);
        @(posedge clk);
        #1;
        mem_axi_bready = 1'b0;
        axi_read("compare_strb", 32'h4, 32'h0034_0078, 0);
        axi_write(32'h4, 32'hFFFF_FFFF, 4'b0000);
        axi_read("compare_nostrb", 32'h4, 32'h0034_0078, 0);

        // Autoreload: PRESCALE=4, COMPARE=3 -> matches every 12 cycles after enable.
        axi_write(32'h4, 32'd3, 4'hF);
        axi_write(32'h0, 32'h7, 4'hF);
        hs = wr_hs;
        wait_until(hs + 11);
        axi_read("pend_before_match", 32'hC, 32'd0, 0);
        axi_read("count_after_reload", 32'h8, 32'd0, 0);
        check("irq_lag_low",  {31'd0, irq_hist[hs + 12]}, 32'd0);
        check("irq_lag_high", {31'd0, irq_hist[hs + 13]}, 32'd1);

        // W1C landing on the next match edge: set wins.
        wait_until(hs + 23);
        axi_write(32'hC, 32'd1, 4'hF);
        check("w1c_on_match_edge", wr_hs, hs + 24);
        axi_read("pend_set_wins", 32'hC, 32'd1, 0);
        check("irq_set_wins_0", {31'd0, irq_hist[hs + 24]}, 32'd1);
        check("irq_set_wins_1", {31'd0, irq_hist[hs + 25]}, 32'd1);

        // W1C on a quiet cycle.
        axi_write(32'hC, 32'd1, 4'hF);
        axi_read("pend_cleared", 32'hC, 32'd0, 0);
        check("irq_clear_lag_hi", {31'd0, irq_hist[wr_hs]},     32'd1);
        check("irq_clear_lag_lo", {31'd0, irq_hist[wr_hs + 1]}, 32'd0);

        // One-shot: CTRL=3, COMPARE=2 -> COUNT stops at 2, enable self-clears.
        axi_write(32'h0, 32'h0, 4'hF);
        axi_write(32'h8, 32'h0, 4'hF);
        axi_write(32'hC, 32'd1, 4'hF);
        axi_write(32'h4, 32'd2, 4'hF);
        axi_write(32'h0, 32'h3, 4'hF);
        hs = wr_hs;
        wait_until(hs + 20);
        axi_read("oneshot_count", 32'h8, 32'd2, 0);
        axi_read("oneshot_ctrl",  32'h0, 32'h2, 0);
        axi_read("oneshot_pend",  32'hC, 32'd1, 0);
        check("oneshot_irq", {31'd0, irq_hist[hs + 9]}, 32'd1);
        wait_until(hs + 40);
        axi_read("oneshot_frozen", 32'h8, 32'd2, 0);

        // COUNT wraps from 2^32-1 to 0; clearing enable freezes it.
        axi_write(32'h0, 32'h0, 4'hF);
        axi_write(32'hC, 32'd1, 4'hF);
        axi_write(32'h4, 32'h10, 4'hF);
        axi_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        axi_write(32'h0, 32'h1, 4'hF);
        hs = wr_hs;
        wait_until(hs + 5);
        axi_read("count_wrap", 32'h8, 32'd0, 0);
        axi_write(32'h0, 32'h0, 4'hF);
        wait_until(hs + 20);
        axi_read("count_frozen", 32'h8, 32'd1, 0);

        // Simultaneous write and read: write first, read right after bvalid handshake.
        mem_axi_awvalid = 1'b1;
        mem_axi_wvalid  = 1'b1;
        mem_axi_awaddr  = 32'h4;
        mem_axi_wdata   = 32'hA5A5_A5A5;
        mem_axi_wstrb   = 4'hF;
        mem_axi_arvalid = 1'b1;
        mem_axi_araddr  = 32'h4;
        @(negedge clk);
        check("both_awready", {30'd0, mem_axi_awready, mem_axi_arready}, 32'd2);
        @(posedge clk);
        #1;
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_bready  = 1'b1;
        @(negedge clk);
        check("both_bvalid", {30'd0, mem_axi_bvalid, mem_axi_arready}, 32'd2);
        @(posedge clk);
        #1;
        mem_axi_bready = 1'b0;
        @(negedge clk);
        check("both_arready", {31'd0, mem_axi_arready}, 32'd1);
        @(posedge clk);
        #1;
        mem_axi_arvalid = 1'b0;
        @(negedge clk);
        check("both_rvalid", {31'd0, mem_axi_rvalid}, 32'd1);
        check("both_rdata", mem_axi_rdata, 32'hA5A5_A5A5);
        mem_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        mem_axi_rready = 1'b0;

        // Reset while bvalid is outstanding.
        mem_axi_awvalid = 1'b1;
        mem_axi_wvalid  = 1'b1;
        mem_axi_awaddr  = 32'h8;
        mem_axi_wdata   = 32'h55;
        mem_axi_wstrb   = 4'hF;
        @(negedge clk);
        check("rstmid_ready", {31'd0, mem_axi_awready}, 32'd1);
        @(posedge clk);
        #1;
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid  = 1'b0;
        @(negedge clk);
        check("rstmid_bvalid_hi", {31'd0, mem_axi_bvalid}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_bvalid_lo", {31'd0, mem_axi_bvalid}, 32'd0);
        check("rstmid_rdata", mem_axi_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        axi_read("rstmid_count",   32'h8, 32'd0, 0);
        axi_read("rstmid_compare", 32'h4, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
